// File: rtl/fsmc_mailbox_pkg.sv
// Shared definitions for the FSMC mailbox: register offsets, STATUS/CTRL bit positions
// and the read-side state encoding.
package fsmc_mailbox_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_LEVEL  = 2'd3;

  localparam int unsigned ST_RX_EMPTY     = 0;
  localparam int unsigned ST_RX_FULL      = 1;
  localparam int unsigned ST_TX_EMPTY     = 2;
  localparam int unsigned ST_TX_FULL      = 3;
  localparam int unsigned ST_RX_UNDERFLOW = 4;
  localparam int unsigned ST_TX_OVERFLOW  = 5;
  localparam int unsigned ST_IRQ_EN       = 8;

  localparam int unsigned CTRL_CLEAR    = 0;
  localparam int unsigned CTRL_FLUSH_TX = 1;
  localparam int unsigned CTRL_FLUSH_RX = 2;
  localparam int unsigned CTRL_IRQ_EN   = 8;

  typedef enum logic [1:0] {
    RdIdle = 2'd0,
    RdS1   = 2'd1,
    RdS2   = 2'd2
  } rd_state_e;

  function automatic logic [15:0] pack_status(
    input logic rx_empty,
    input logic rx_full,
    input logic tx_empty,
    input logic tx_full,
    input logic rx_underflow,
    input logic tx_overflow,
    input logic irq_en
  );
    logic [15:0] s;
    s                  = '0;
    s[ST_RX_EMPTY]     = rx_empty;
    s[ST_RX_FULL]      = rx_full;
    s[ST_TX_EMPTY]     = tx_empty;
    s[ST_TX_FULL]      = tx_full;
    s[ST_RX_UNDERFLOW] = rx_underflow;
    s[ST_TX_OVERFLOW]  = tx_overflow;
    s[ST_IRQ_EN]       = irq_en;
    return s;
  endfunction

endpackage

// File: rtl/fsmc_mailbox_fifo.sv
// Synchronous show-ahead FIFO with a registered head word, flush, count, empty and full.
module mailbox_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  do_push, do_pop;

  assign empty = (count_q == '0);
  // Count never exceeds DEPTH, so the MSB alone marks full.
  assign full  = count_q[DEPTH_LOG2];
  assign count = count_q;
  assign data  = data_q;

  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & (~full | do_pop) & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // The next head either comes from RAM or is the word being written into the head slot.
  always_comb begin
    if (flush) begin
      data_d = '0;
    end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      data_d = wdata;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/fsmc_mailbox.sv
// Avalon-MM 16-bit slave behind the FSMC master: MCU writes feed a TX stream FIFO, MCU reads
// drain an RX stream FIFO, plus status, sticky errors, flush control and a level interrupt.
module fsmc_mailbox
  import fsmc_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        avs_clk,
  input  logic        avs_reset_n,
  input  logic [31:0] avs_addr,
  input  logic        avs_rd,
  input  logic        avs_wr,
  input  logic [15:0] avs_wdata,
  output logic [15:0] avs_rdata,
  output logic        avs_rdvalid,
  output logic        avs_wait,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  logic [1:0]          reg_sel;
  logic                unused_addr;
  rd_state_e           rd_state_q, rd_state_d;
  logic                rd_accept, wr_data, wr_ctrl;
  logic                tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic                rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic [15:0]         rx_head;
  logic                sticky_clr, ovf_err, unf_err;
  logic                tx_overflow_q, tx_overflow_d;
  logic                rx_underflow_q, rx_underflow_d;
  logic                irq_en_q, irq_en_d, irq_q;
  logic [15:0]         rd_mux, snap_q, rdata_q, rdata_d;
  logic                rdvalid_q, rdvalid_d;

  assign reg_sel     = avs_addr[2:1];
  assign unused_addr = ^{avs_addr[31:3], avs_addr[0]};

  assign rd_accept = avs_rd & (rd_state_q == RdIdle);
  assign avs_wait  = avs_rd & (rd_state_q != RdIdle);
  assign wr_data   = avs_wr & (reg_sel == REG_DATA);
  assign wr_ctrl   = avs_wr & (reg_sel == REG_CTRL);

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push  = wr_data;
  assign tx_flush = wr_ctrl & avs_wdata[CTRL_FLUSH_TX];

  assign rx_pop   = rd_accept & (reg_sel == REG_DATA) & ~rx_empty;
  // A full RX still takes a word when the MCU pops in the same cycle.
  assign rx_ready = ~rx_full | rx_pop;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_flush = wr_ctrl & avs_wdata[CTRL_FLUSH_RX];

  assign sticky_clr = wr_ctrl & avs_wdata[CTRL_CLEAR];
  assign ovf_err    = wr_data & tx_full & ~tx_pop;
  assign unf_err    = rd_accept & (reg_sel == REG_DATA) & rx_empty;

  // A new error in the same cycle as a clear keeps the flag set.
  assign tx_overflow_d  = (tx_overflow_q & ~sticky_clr) | ovf_err;
  assign rx_underflow_d = (rx_underflow_q & ~sticky_clr) | unf_err;
  assign irq_en_d       = wr_ctrl ? avs_wdata[CTRL_IRQ_EN] : irq_en_q;

  mailbox_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (16)
  ) u_tx_fifo (
    .clk   (avs_clk),
    .rst_n (avs_reset_n),
    .push  (tx_push),
    .wdata (avs_wdata),
    .pop   (tx_pop),
    .flush (tx_flush),
    .data  (tx_data),
    .count (tx_count),
    .empty (tx_empty),
    .full  (tx_full)
  );

  mailbox_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (16)
  ) u_rx_fifo (
    .clk   (avs_clk),
    .rst_n (avs_reset_n),
    .push  (rx_push),
    .wdata (rx_data),
    .pop   (rx_pop),
    .flush (rx_flush),
    .data  (rx_head),
    .count (rx_count),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_DATA:   rd_mux = rx_empty ? 16'h0000 : rx_head;
      REG_STATUS: rd_mux = pack_status(rx_empty, rx_full, tx_empty, tx_full,
                                       rx_underflow_q, tx_overflow_q, irq_en_q);
      REG_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en_q;
      REG_LEVEL:  rd_mux = {8'(tx_count), 8'(rx_count)};
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rdvalid_d  = 1'b0;
    case (rd_state_q)
      RdIdle: if (avs_rd) rd_state_d = RdS1;
      RdS1: begin
        rd_state_d = RdS2;
        rdata_d    = snap_q;
        rdvalid_d  = 1'b1;
      end
      RdS2:    rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge avs_clk or negedge avs_reset_n) begin
    if (!avs_reset_n) begin
      rd_state_q     <= RdIdle;
      snap_q         <= '0;
      rdata_q        <= '0;
      rdvalid_q      <= 1'b0;
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
      irq_en_q       <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      rd_state_q     <= rd_state_d;
      if (rd_accept) snap_q <= rd_mux;
      rdata_q        <= rdata_d;
      rdvalid_q      <= rdvalid_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_underflow_q <= rx_underflow_d;
      irq_en_q       <= irq_en_d;
      irq_q          <= irq_en_q & ~rx_empty;
    end
  end

  assign avs_rdata   = rdata_q;
  assign avs_rdvalid = rdvalid_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_fsmc_mailbox.sv
// Scoreboard bench for fsmc_mailbox: a queue-based mailbox model predicts read data, stream
// outputs and interrupt; a monitor compares the DUT against it every cycle.
module tb_fsmc_mailbox;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] avs_addr = '0;
  logic        avs_rd = 1'b0, avs_wr = 1'b0;
  logic [15:0] avs_wdata = '0;
  logic [15:0] avs_rdata;
  logic        avs_rdvalid, avs_wait;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, irq;

  always #5 clk = ~clk;

  fsmc_mailbox #(.DEPTH_LOG2(4)) dut (
    .avs_clk     (clk),
    .avs_reset_n (rst_n),
    .avs_addr    (avs_addr),
    .avs_rd      (avs_rd),
    .avs_wr      (avs_wr),
    .avs_wdata   (avs_wdata),
    .avs_rdata   (avs_rdata),
    .avs_rdvalid (avs_rdvalid),
    .avs_wait    (avs_wait),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .irq         (irq)
  );

  int total = 0;
  int bad = 0;
  longint cyc = 0;

  // Mailbox model: word queues, sticky flags, and a countdown of cycles the read port is busy.
  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  bit m_ovf, m_unf, m_irq_en, m_irq;
  int m_busy;
  bit last_accept;

  typedef struct {
    logic [15:0] data;
    longint      due;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial begin : model
    int txn, rxn;
    bit tx_pop, acc, rx_pop, ctrl_wr, ovf_new, unf_new, clr;
    logic [1:0] r;
    logic [15:0] v;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_tx.delete(); m_rx.delete(); exp_q.delete();
        m_ovf = 0; m_unf = 0; m_irq_en = 0; m_irq = 0; m_busy = 0; last_accept = 0;
      end else begin
        txn = m_tx.size(); rxn = m_rx.size();
        r = avs_addr[2:1];
        tx_pop = tx_ready && (txn > 0);
        acc = avs_rd && (m_busy == 0);
        rx_pop = 0; ovf_new = 0; unf_new = 0;
        ctrl_wr = avs_wr && (r == 2'd2);
        clr = ctrl_wr && avs_wdata[0];
        m_irq = m_irq_en && (rxn > 0);
        if (acc) begin
          case (r)
            2'd0: if (rxn > 0) begin v = m_rx.pop_front(); rx_pop = 1; end
                  else begin v = 16'h0000; unf_new = 1; end
            2'd1: v = 16'((m_irq_en ? 256 : 0) + (m_ovf ? 32 : 0) + (m_unf ? 16 : 0) +
                         ((txn == DEPTH) ? 8 : 0) + ((txn == 0) ? 4 : 0) +
                         ((rxn == DEPTH) ? 2 : 0) + ((rxn == 0) ? 1 : 0));
            2'd2: v = m_irq_en ? 16'h0100 : 16'h0000;
            default: v = 16'(txn * 256 + rxn);
          endcase
          exp_q.push_back('{data: v, due: cyc + 2});
        end
        m_busy = acc ? 2 : ((m_busy > 0) ? m_busy - 1 : 0);
        if (tx_pop) void'(m_tx.pop_front());
        if (avs_wr && r == 2'd0) begin
          if (txn < DEPTH || tx_pop) m_tx.push_back(avs_wdata);
          else ovf_new = 1;
        end
        if (ctrl_wr) begin
          if (avs_wdata[1]) m_tx.delete();
          if (avs_wdata[2]) m_rx.delete();
          m_irq_en = avs_wdata[8];
        end
        if (rx_valid && (rxn < DEPTH || rx_pop) && !(ctrl_wr && avs_wdata[2]))
          m_rx.push_back(rx_data);
        m_ovf = (m_ovf && !clr) || ovf_new;
        m_unf = (m_unf && !clr) || unf_new;
        last_accept = acc;
      end
      cyc++;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("avs_wait", 32'(avs_wait), 32'(avs_rd && m_busy != 0));
        check("tx_valid", 32'(tx_valid), 32'(m_tx.size() > 0));
        if (m_tx.size() > 0) check("tx_data", 32'(tx_data), 32'(m_tx[0]));
        check("irq", 32'(irq), 32'(m_irq));
        check("rx_ready", 32'(rx_ready), 32'(m_rx.size() < DEPTH ||
              (avs_rd && m_busy == 0 && avs_addr[2:1] == 2'd0 && m_rx.size() > 0)));
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL rdvalid_missing: no rdvalid at cycle %0d, required data 0x%0h", e.due, e.data);
      end
      if (avs_rdvalid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rdvalid_unexpected: rdvalid with data 0x%0h at cycle %0d, none required",
                   avs_rdata, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rdvalid_cycle", 32'(cyc), 32'(e.due));
          check("rdata", 32'(avs_rdata), 32'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] r);
    avs_addr = $urandom;
    avs_addr[2:1] = r;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [15:0] d);
    set_addr(r); avs_wdata = d; avs_wr = 1'b1; avs_rd = 1'b0;
    step();
    avs_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] r);
    int n;
    set_addr(r); avs_rd = 1'b1; avs_wr = 1'b0; n = 0;
    do begin step(); n++; end while (!last_accept && n < 8);
    check("read_accepted", 32'(last_accept), 32'd1);
    avs_rd = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_rdata", 32'(avs_rdata), 32'h0);
    check("rst_rdvalid", 32'(avs_rdvalid), 32'h0);
    check("rst_wait", 32'(avs_wait), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int accepts, n, op;
    step(); step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();

    bus_read(2'd1);
    bus_read(2'd3);

    tx_ready = 1'b0;
    bus_write(2'd0, 16'h1234);
    bus_write(2'd0, 16'hABCD);
    bus_read(2'd3);
    tx_ready = 1'b1;
    repeat (4) step();
    tx_ready = 1'b0;

    for (int i = 0; i < DEPTH + 1; i++) bus_write(2'd0, 16'(16'h0A00 + i));
    bus_read(2'd1);
    bus_write(2'd2, 16'h0001);
    bus_read(2'd1);
    bus_write(2'd2, 16'h0002);

    bus_write(2'd2, 16'h0100);
    rx_data = 16'h55AA; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    repeat (2) step();
    bus_read(2'd0);
    repeat (3) step();
    bus_read(2'd0);
    bus_read(2'd1);

    // Two back-to-back reads with avs_rd held throughout.
    set_addr(2'd1); avs_rd = 1'b1; accepts = 0; n = 0;
    while (accepts < 2 && n < 12) begin
      step(); n++;
      if (last_accept) accepts++;
    end
    check("b2b_accepts", 32'(accepts), 32'd2);
    avs_rd = 1'b0;
    repeat (3) step();

    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 16'(16'hC000 + i);
      step();
    end
    rx_valid = 1'b0;
    step();
    // Full RX: push and pop land in the same cycle.
    rx_data = 16'hC0FF; rx_valid = 1'b1; set_addr(2'd0); avs_rd = 1'b1;
    step();
    rx_valid = 1'b0; avs_rd = 1'b0;
    repeat (2) step();
    bus_read(2'd3);
    for (int i = 0; i < DEPTH + 1; i++) bus_read(2'd0);

    bus_write(2'd0, 16'h7777);
    set_addr(2'd1); avs_rd = 1'b1;
    step();
    avs_rd = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();

    for (int c = 0; c < 4000; c++) begin
      tx_ready = (c < 1200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      rx_valid = (c < 2000) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      rx_data = 16'($urandom);
      if (!(avs_rd && !last_accept)) begin
        avs_rd = 1'b0; avs_wr = 1'b0;
        op = $urandom_range(0, 19);
        if (op <= 5) begin
          set_addr(2'd0); avs_wdata = 16'($urandom); avs_wr = 1'b1;
        end else if (op <= 9) begin
          set_addr(2'd0); avs_rd = 1'b1;
        end else if (op <= 12) begin
          set_addr(2'(op - 9)); avs_rd = 1'b1;
        end else if (op == 13) begin
          set_addr(2'd2);
          avs_wdata = 16'($urandom) & 16'h0101;
          if ($urandom_range(0, 15) == 0) avs_wdata[2:1] = 2'($urandom_range(1, 3));
          avs_wr = 1'b1;
        end else if (op == 14) begin
          set_addr($urandom_range(0, 1) == 0 ? 2'd1 : 2'd3);
          avs_wdata = 16'($urandom); avs_wr = 1'b1;
        end
      end
      step();
    end
    avs_rd = 1'b0; avs_wr = 1'b0; rx_valid = 1'b0;
    repeat (6) step();
    check("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
